// File: rtl/sqrt_unit.sv
// sqrt_unit: parametrised integer square root, restoring digit-by-digit.
// Accepts a radicand on a valid/ready handshake, runs N/2 iterations (one per
// clock), then presents a floor or round-to-nearest root plus the floor
// remainder until the consumer takes it. Also keeps a free-running cycle count.
module sqrt_unit #(
    parameter int N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   data_in,
    input  logic           round_mode,
    input  logic           start,
    output logic           in_ready,
    output logic [N/2:0]   data_out,
    output logic [N/2:0]   remainder,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    cycles
);

    // H: root width; W: partial-remainder width (two guard bits over the root)
    localparam int H  = N / 2;
    localparam int W  = H + 2;
    localparam int IW = (H > 1) ? $clog2(H) : 1;

    generate
        if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
            $error("sqrt_unit: N must be even and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   x_sh_reg, x_sh_next;
    logic           mode_reg, mode_next;
    logic [W-1:0]   rem_reg, rem_next;
    logic [H-1:0]   root_reg, root_next;
    logic [IW-1:0]  iter_reg, iter_next;
    logic [H:0]     data_out_reg, data_out_next;
    logic [H:0]     remainder_reg, remainder_next;
    logic [31:0]    cycles_reg, cycles_next;

    // One restoring iteration: bring down the next two radicand bits and try
    // subtracting (4*root + 1).
    logic [W-1:0]   rem_shift;
    logic [W-1:0]   trial;
    logic           take;
    logic [W-1:0]   rem_iter;
    logic [H-1:0]   root_iter;

    // Iteration datapath, evaluated every cycle but only committed in CALC
    always_comb begin
        rem_shift = (rem_reg << 2) | W'(x_sh_reg[N-1:N-2]);
        trial     = {root_reg, 2'b01};
        take      = (rem_shift >= trial);
        rem_iter  = take ? (rem_shift - trial) : rem_shift;
        root_iter = (root_reg << 1) | H'(take);
    end

    // Next-state and next-register logic for the FSM and datapath
    always_comb begin
        state_next     = state_reg;
        x_sh_next      = x_sh_reg;
        mode_next      = mode_reg;
        rem_next       = rem_reg;
        root_next      = root_reg;
        iter_next      = iter_reg;
        data_out_next  = data_out_reg;
        remainder_next = remainder_reg;
        cycles_next    = cycles_reg + 32'd1;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    x_sh_next  = data_in;
                    mode_next  = round_mode;
                    rem_next   = '0;
                    root_next  = '0;
                    iter_next  = IW'(H - 1);
                    state_next = CALC;
                end
            end
            CALC: begin
                x_sh_next = x_sh_reg << 2;
                rem_next  = rem_iter;
                root_next = root_iter;
                if (iter_reg == '0) begin
                    remainder_next = rem_iter[H:0];
                    // Round up when the remainder exceeds the root, i.e. the
                    // radicand is past (root + 0.5)^2; may reach 2^H.
                    if (mode_reg && (rem_iter > W'(root_iter))) begin
                        data_out_next = {1'b0, root_iter} + (H+1)'(1);
                    end else begin
                        data_out_next = {1'b0, root_iter};
                    end
                    state_next = DONE;
                end else begin
                    iter_next = iter_reg - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            x_sh_reg      <= '0;
            mode_reg      <= 1'b0;
            rem_reg       <= '0;
            root_reg      <= '0;
            iter_reg      <= '0;
            data_out_reg  <= '0;
            remainder_reg <= '0;
            cycles_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            x_sh_reg      <= x_sh_next;
            mode_reg      <= mode_next;
            rem_reg       <= rem_next;
            root_reg      <= root_next;
            iter_reg      <= iter_next;
            data_out_reg  <= data_out_next;
            remainder_reg <= remainder_next;
            cycles_reg    <= cycles_next;
        end
    end

    // Handshake flags come straight from the state register
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign data_out  = data_out_reg;
    assign remainder = remainder_reg;
    assign cycles    = cycles_reg;

endmodule

// File: tb/tb_sqrt_unit.sv
// tb_sqrt_unit: directed and swept checks of sqrt_unit at N=8 and N=16.
module tb_sqrt_unit;

    logic        clock;
    logic        reset;

    logic [7:0]  d8_in;
    logic        mode8;
    logic        start8;
    logic        in_ready8;
    logic [4:0]  do8;
    logic [4:0]  rem8;
    logic        out_valid8;
    logic        out_ready8;
    logic [31:0] cycles8;

    logic [15:0] d16_in;
    logic        mode16;
    logic        start16;
    logic        in_ready16;
    logic [8:0]  do16;
    logic [8:0]  rem16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] cycles16;

    int checks;
    int failures;

    sqrt_unit #(.N(8)) dut8 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (d8_in),
        .round_mode (mode8),
        .start      (start8),
        .in_ready   (in_ready8),
        .data_out   (do8),
        .remainder  (rem8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .cycles     (cycles8)
    );

    sqrt_unit #(.N(16)) dut16 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (d16_in),
        .round_mode (mode16),
        .start      (start16),
        .in_ready   (in_ready16),
        .data_out   (do16),
        .remainder  (rem16),
        .out_valid  (out_valid16),
        .out_ready  (out_ready16),
        .cycles     (cycles16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one operation on the selected DUT. Called #1 after a rising edge
    // with the DUT idle; returns #1 after the handoff edge. lat counts edges
    // from accept to out_valid (capped at 40 when the result never comes).
    task automatic run_op(input bit wide, input logic [15:0] x, input bit mode,
                          output logic [8:0] root, output logic [8:0] rem,
                          output int lat);
        if (wide) begin
            d16_in = x; mode16 = mode; start16 = 1'b1;
        end else begin
            d8_in = x[7:0]; mode8 = mode; start8 = 1'b1;
        end
        @(posedge clock);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (lat != 0 && (wide ? out_valid16 : out_valid8)) break;
            @(posedge clock);
            #1;
            lat++;
        end
        root = wide ? do16 : {4'd0, do8};
        rem  = wide ? rem16 : {4'd0, rem8};
        out_ready8 = 1'b1;
        out_ready16 = 1'b1;
        @(posedge clock);
        #1;
        out_ready8 = 1'b0;
        out_ready16 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid8); end
        checks++; if (do8 !== 5'd0) begin failures++; $display("FAIL reset_data_out got=%0d want=0", do8); end
        checks++; if (rem8 !== 5'd0) begin failures++; $display("FAIL reset_remainder got=%0d want=0", rem8); end
        checks++; if (cycles8 !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d want=0", cycles8); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (cycles8 !== 32'd1) begin failures++; $display("FAIL cycles_step1 got=%0d want=1", cycles8); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (cycles8 !== 32'd4) begin failures++; $display("FAIL cycles_step4 got=%0d want=4", cycles8); end
        $display("reset: cycles=%0d in_ready=%b", cycles8, in_ready8);
    endtask

    task automatic test_zero();
        logic [8:0] r, m;
        int lat;
        run_op(1'b0, 16'd0, 1'b0, r, m, lat);
        $display("n8 x=0 floor -> root=%0d rem=%0d lat=%0d", r, m, lat);
        checks++; if (r !== 9'd0) begin failures++; $display("FAIL zero_root got=%0d want=0", r); end
        checks++; if (m !== 9'd0) begin failures++; $display("FAIL zero_rem got=%0d want=0", m); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency got=%0d want=4", lat); end
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL zero_idle_after got=%b want=1", in_ready8); end
    endtask

    task automatic test_directed8();
        // x, mode, root, rem
        int vec [8][4] = '{
            '{255, 0, 15, 30}, '{255, 1, 16, 30},
            '{144, 0, 12, 0},  '{144, 1, 12, 0},
            '{210, 1, 14, 14}, '{211, 1, 15, 15},
            '{200, 1, 14, 4},  '{2,   1, 1,  1}
        };
        logic [8:0] r, m;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, 16'(vec[i][0]), vec[i][1][0], r, m, lat);
            $display("n8 x=%0d mode=%0d -> root=%0d rem=%0d lat=%0d", vec[i][0], vec[i][1], r, m, lat);
            checks++; if (r !== 9'(vec[i][2])) begin failures++; $display("FAIL n8_root x=%0d mode=%0d got=%0d want=%0d", vec[i][0], vec[i][1], r, vec[i][2]); end
            checks++; if (m !== 9'(vec[i][3])) begin failures++; $display("FAIL n8_rem x=%0d mode=%0d got=%0d want=%0d", vec[i][0], vec[i][1], m, vec[i][3]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL n8_latency x=%0d got=%0d want=4", vec[i][0], lat); end
        end
    endtask

    task automatic test_back_pressure();
        logic [8:0] r, m;
        int lat;
        d8_in = 8'd100; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++; if (out_valid8 !== 1'b1) begin failures++; $display("FAIL bp_valid_rise got=%b want=1", out_valid8); end
        for (int i = 0; i < 5; i++) begin
            start8 = ~start8;
            d8_in = 8'(i * 37 + 5);
            mode8 = ~mode8;
            @(posedge clock);
            #1;
            checks++; if (out_valid8 !== 1'b1) begin failures++; $display("FAIL bp_valid_hold c=%0d got=%b want=1", i, out_valid8); end
            checks++; if (do8 !== 5'd10) begin failures++; $display("FAIL bp_data_hold c=%0d got=%0d want=10", i, do8); end
            checks++; if (rem8 !== 5'd0) begin failures++; $display("FAIL bp_rem_hold c=%0d got=%0d want=0", i, rem8); end
            checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b want=0", i, in_ready8); end
        end
        start8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clock);
        #1;
        out_ready8 = 1'b0;
        $display("backpressure: held root=%0d rem=%0d, released in_ready=%b", do8, rem8, in_ready8);
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out_valid8); end
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", in_ready8); end
        run_op(1'b0, 16'd49, 1'b0, r, m, lat);
        $display("n8 x=49 floor -> root=%0d rem=%0d lat=%0d", r, m, lat);
        checks++; if (r !== 9'd7) begin failures++; $display("FAIL bp_next_root got=%0d want=7", r); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL bp_next_latency got=%0d want=4", lat); end
    endtask

    task automatic test_reset_mid_calc();
        logic [8:0] r, m;
        int lat;
        d8_in = 8'd255; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        $display("reset mid-calc: in_ready=%b out_valid=%b cycles=%0d", in_ready8, out_valid8, cycles8);
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid8); end
        checks++; if (do8 !== 5'd0) begin failures++; $display("FAIL midrst_data_out got=%0d want=0", do8); end
        checks++; if (rem8 !== 5'd0) begin failures++; $display("FAIL midrst_remainder got=%0d want=0", rem8); end
        checks++; if (cycles8 !== 32'd0) begin failures++; $display("FAIL midrst_cycles got=%0d want=0", cycles8); end
        run_op(1'b0, 16'd169, 1'b1, r, m, lat);
        $display("n8 x=169 round -> root=%0d rem=%0d lat=%0d", r, m, lat);
        checks++; if (r !== 9'd13) begin failures++; $display("FAIL midrst_next_root got=%0d want=13", r); end
        checks++; if (m !== 9'd0) begin failures++; $display("FAIL midrst_next_rem got=%0d want=0", m); end
    endtask

    task automatic test_n16();
        logic [8:0] r, m;
        int lat;
        int x, fr, er, em;
        run_op(1'b1, 16'hFFFF, 1'b0, r, m, lat);
        $display("n16 x=65535 floor -> root=%0d rem=%0d lat=%0d", r, m, lat);
        checks++; if (r !== 9'd255) begin failures++; $display("FAIL n16_max_floor got=%0d want=255", r); end
        checks++; if (m !== 9'd510) begin failures++; $display("FAIL n16_max_rem got=%0d want=510", m); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL n16_latency got=%0d want=8", lat); end
        run_op(1'b1, 16'hFFFF, 1'b1, r, m, lat);
        $display("n16 x=65535 round -> root=%0d rem=%0d lat=%0d", r, m, lat);
        checks++; if (r !== 9'd256) begin failures++; $display("FAIL n16_max_round got=%0d want=256", r); end
        checks++; if (m !== 9'd510) begin failures++; $display("FAIL n16_max_round_rem got=%0d want=510", m); end
        for (int i = 0; i < 1000; i++) begin
            x = int'($urandom_range(65535, 0));
            fr = 0;
            while ((fr + 1) * (fr + 1) <= x) fr++;
            em = x - fr * fr;
            for (int md = 0; md < 2; md++) begin
                er = (md == 1 && em > fr) ? fr + 1 : fr;
                run_op(1'b1, 16'(x), md[0], r, m, lat);
                $display("n16 x=%0d mode=%0d -> root=%0d rem=%0d", x, md, r, m);
                checks++; if (r !== 9'(er)) begin failures++; $display("FAIL n16_root x=%0d mode=%0d got=%0d want=%0d", x, md, r, er); end
                checks++; if (m !== 9'(em)) begin failures++; $display("FAIL n16_rem x=%0d mode=%0d got=%0d want=%0d", x, md, m, em); end
                checks++; if (lat !== 8) begin failures++; $display("FAIL n16_lat x=%0d got=%0d want=8", x, lat); end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        d8_in = '0; mode8 = 1'b0; start8 = 1'b0; out_ready8 = 1'b0;
        d16_in = '0; mode16 = 1'b0; start16 = 1'b0; out_ready16 = 1'b0;
        test_reset();
        test_zero();
        test_directed8();
        test_back_pressure();
        test_reset_mid_calc();
        test_n16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
